// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one asynchronous-read byte memory between a fetch port
// and a data port. Each access takes three cycles: IDLE (arbitrate), ACC
// (memory access with latched request), RESP (one-cycle valid pulse).
// Data normally has priority over fetch. Defining ARB_STARVE_GUARD_EN adds a
// saturating streak counter that hands the memory to fetch once MAX_STREAK
// data grants in a row have been taken while fetch was waiting.
// Load type encoding:  0=LB 1=LH 2=LW 3=LBU 4=LHU.  Store type: 0=SB 1=SH 2=SW.
`timescale 1ns/1ps

`ifndef LOAD_B
`define LOAD_B  3'd0
`endif
`ifndef LOAD_H
`define LOAD_H  3'd1
`endif
`ifndef LOAD_W
`define LOAD_W  3'd2
`endif
`ifndef LOAD_BU
`define LOAD_BU 3'd3
`endif
`ifndef LOAD_HU
`define LOAD_HU 3'd4
`endif

module mem_arbiter #(
   parameter int MAX_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   // fetch side
   input  logic        if_req_i,
   input  logic [7:0]  if_addr_i,
   output logic        if_valid_o,
   output logic [31:0] if_rdata_o,
   output logic        if_stall_o,
   // data side
   input  logic        dm_req_i,
   input  logic        dm_we_i,
   input  logic [7:0]  dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   input  logic [2:0]  dm_load_type_i,
   input  logic [1:0]  dm_store_type_i,
   output logic        dm_valid_o,
   output logic [31:0] dm_rdata_o,
   output logic        dm_stall_o,
   // memory side
   output logic        mem_rd_en_o,
   output logic        mem_wr_en_o,
   output logic [7:0]  mem_addr_o,
   output logic [31:0] mem_wr_data_o,
   output logic [2:0]  mem_load_type_o,
   output logic [1:0]  mem_store_type_o,
   input  logic [31:0] mem_rd_data_i
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      IF_ACC  = 3'd1,
      DM_ACC  = 3'd2,
      IF_RESP = 3'd3,
      DM_RESP = 3'd4
   } state_t;

   state_t state_r;
   logic   lat_we_r;     // latched direction of the current data access
   logic   grant_dm_s;   // data would win arbitration this cycle
   logic   take_dm_s;    // data grant taken at this edge
   logic   take_if_s;    // fetch grant taken at this edge

   if ((MAX_STREAK < 1) || (MAX_STREAK > 15)) begin : g_bad_max_streak
      $error("mem_arbiter: MAX_STREAK must be within 1..15");
   end

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [3:0] STREAK_LIMIT = 4'(MAX_STREAK);

   logic [3:0] streak_r;

   // saturating increment so a long data burst cannot wrap the counter
   function automatic logic [3:0] streak_inc(input logic [3:0] cnt);
      logic [3:0] nxt;
      if (cnt == 4'd15) begin
         nxt = 4'd15;
      end else begin
         nxt = cnt + 4'd1;
      end
      return nxt;
   endfunction

   // Data priority, except fetch wins once the streak limit is reached
   always_comb begin
      grant_dm_s = dm_req_i;
      if (dm_req_i && if_req_i && (streak_r == STREAK_LIMIT)) begin
         grant_dm_s = 1'b0;
      end else begin
         grant_dm_s = dm_req_i;
      end
   end

   // Count data grants taken while fetch waits; a fetch grant clears it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         streak_r <= 4'd0;
      end else if (take_if_s) begin
         streak_r <= 4'd0;
      end else if (take_dm_s && if_req_i) begin
         streak_r <= streak_inc(streak_r);
      end else begin
         streak_r <= streak_r;
      end
   end
`else
   // Strict data priority
   always_comb begin
      grant_dm_s = dm_req_i;
   end
`endif

   assign take_dm_s = (state_r == IDLE) && grant_dm_s;
   assign take_if_s = (state_r == IDLE) && !grant_dm_s && if_req_i;

   // Stalls follow the live request until its valid cycle
   assign if_stall_o = if_req_i & ~if_valid_o;
   assign dm_stall_o = dm_req_i & ~dm_valid_o;

   // Arbitration FSM: latches the granted request, drives memory, captures data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r          <= IDLE;
         lat_we_r         <= 1'b0;
         mem_rd_en_o      <= 1'b0;
         mem_wr_en_o      <= 1'b0;
         mem_addr_o       <= 8'd0;
         mem_wr_data_o    <= 32'd0;
         mem_load_type_o  <= 3'd0;
         mem_store_type_o <= 2'd0;
         if_valid_o       <= 1'b0;
         if_rdata_o       <= 32'd0;
         dm_valid_o       <= 1'b0;
         dm_rdata_o       <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (take_dm_s) begin
                  state_r          <= DM_ACC;
                  lat_we_r         <= dm_we_i;
                  mem_rd_en_o      <= ~dm_we_i;
                  mem_wr_en_o      <= dm_we_i;
                  mem_addr_o       <= dm_addr_i;
                  mem_wr_data_o    <= dm_wdata_i;
                  mem_load_type_o  <= dm_load_type_i;
                  mem_store_type_o <= dm_store_type_i;
               end else if (take_if_s) begin
                  state_r          <= IF_ACC;
                  lat_we_r         <= 1'b0;
                  mem_rd_en_o      <= 1'b1;
                  mem_wr_en_o      <= 1'b0;
                  mem_addr_o       <= if_addr_i;
                  mem_wr_data_o    <= 32'd0;
                  mem_load_type_o  <= `LOAD_W;
                  mem_store_type_o <= 2'd0;
               end else begin
                  state_r <= IDLE;
               end
            end
            IF_ACC: begin
               if_rdata_o  <= mem_rd_data_i;
               if_valid_o  <= 1'b1;
               mem_rd_en_o <= 1'b0;
               mem_wr_en_o <= 1'b0;
               state_r     <= IF_RESP;
            end
            DM_ACC: begin
               // a store leaves the previous load data untouched
               if (!lat_we_r) begin
                  dm_rdata_o <= mem_rd_data_i;
               end else begin
                  dm_rdata_o <= dm_rdata_o;
               end
               dm_valid_o  <= 1'b1;
               mem_rd_en_o <= 1'b0;
               mem_wr_en_o <= 1'b0;
               state_r     <= DM_RESP;
            end
            IF_RESP: begin
               if_valid_o <= 1'b0;
               state_r    <= IDLE;
            end
            DM_RESP: begin
               dm_valid_o <= 1'b0;
               state_r    <= IDLE;
            end
            default: begin
               mem_rd_en_o <= 1'b0;
               mem_wr_en_o <= 1'b0;
               if_valid_o  <= 1'b0;
               dm_valid_o  <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors against mem_arbiter with a byte-memory model.
`timescale 1ns/1ps

module tb_mem_arbiter;

   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LH  = 3'd1;
   localparam logic [2:0] LW  = 3'd2;
   localparam logic [2:0] LBU = 3'd3;
   localparam logic [2:0] LHU = 3'd4;
   localparam logic [1:0] SB  = 2'd0;
   localparam logic [1:0] SH  = 2'd1;
   localparam logic [1:0] SW  = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i;
   logic [7:0]  if_addr_i;
   logic        if_valid_o;
   logic [31:0] if_rdata_o;
   logic        if_stall_o;
   logic        dm_req_i;
   logic        dm_we_i;
   logic [7:0]  dm_addr_i;
   logic [31:0] dm_wdata_i;
   logic [2:0]  dm_load_type_i;
   logic [1:0]  dm_store_type_i;
   logic        dm_valid_o;
   logic [31:0] dm_rdata_o;
   logic        dm_stall_o;
   logic        mem_rd_en_o;
   logic        mem_wr_en_o;
   logic [7:0]  mem_addr_o;
   logic [31:0] mem_wr_data_o;
   logic [2:0]  mem_load_type_o;
   logic [1:0]  mem_store_type_o;
   logic [31:0] mem_rd_data_i;

   int checks   = 0;
   int failures = 0;

   mem_arbiter #(.MAX_STREAK(2)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_valid_o(if_valid_o),
      .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
      .dm_wdata_i(dm_wdata_i), .dm_load_type_i(dm_load_type_i),
      .dm_store_type_i(dm_store_type_i), .dm_valid_o(dm_valid_o),
      .dm_rdata_o(dm_rdata_o), .dm_stall_o(dm_stall_o),
      .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
      .mem_addr_o(mem_addr_o), .mem_wr_data_o(mem_wr_data_o),
      .mem_load_type_o(mem_load_type_o), .mem_store_type_o(mem_store_type_o),
      .mem_rd_data_i(mem_rd_data_i)
   );

   always #5 clk = ~clk;

   // byte memory model: asynchronous typed read, typed write on rising edge
   logic [7:0] mem [256];
   logic [7:0] b0, b1, b2, b3;

   always_comb begin
      b0 = mem[mem_addr_o];
      b1 = mem[mem_addr_o + 8'd1];
      b2 = mem[mem_addr_o + 8'd2];
      b3 = mem[mem_addr_o + 8'd3];
      case (mem_load_type_o)
         LB:      mem_rd_data_i = {{24{b0[7]}}, b0};
         LH:      mem_rd_data_i = {{16{b1[7]}}, b1, b0};
         LW:      mem_rd_data_i = {b3, b2, b1, b0};
         LBU:     mem_rd_data_i = {24'd0, b0};
         LHU:     mem_rd_data_i = {16'd0, b1, b0};
         default: mem_rd_data_i = 32'd0;
      endcase
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'h93; mem[8'h11] = 8'h00; mem[8'h12] = 8'hA0; mem[8'h13] = 8'h00;
      mem[8'h30] = 8'hA5; mem[8'h31] = 8'hA5; mem[8'h32] = 8'hA5; mem[8'h33] = 8'hA5;
      forever begin
         @(posedge clk);
         if (mem_wr_en_o) begin
            mem[mem_addr_o] <= mem_wr_data_o[7:0];
            if (mem_store_type_o == SH || mem_store_type_o == SW)
               mem[mem_addr_o + 8'd1] <= mem_wr_data_o[15:8];
            if (mem_store_type_o == SW) begin
               mem[mem_addr_o + 8'd2] <= mem_wr_data_o[23:16];
               mem[mem_addr_o + 8'd3] <= mem_wr_data_o[31:24];
            end
         end
      end
   end

   typedef struct {
      logic        if_req;
      logic [7:0]  if_addr;
      logic        dm_req;
      logic        dm_we;
      logic [7:0]  dm_addr;
      logic [31:0] dm_wdata;
      logic [2:0]  dm_lt;
      logic [1:0]  dm_st;
      logic        e_rd;
      logic        e_wr;
      logic [7:0]  e_addr;
      logic        e_ifv;
      logic [31:0] e_ifd;
      logic        e_dmv;
      logic [31:0] e_dmd;
      logic        e_ifst;
      logic        e_dmst;
   } vec_t;

   vec_t vecs [15];

   function automatic vec_t mk(
      input logic ir, input logic [7:0] ia,
      input logic dr, input logic dw, input logic [7:0] da,
      input logic [31:0] dd, input logic [2:0] lt, input logic [1:0] st,
      input logic erd, input logic ewr, input logic [7:0] ea,
      input logic eifv, input logic [31:0] eifd,
      input logic edmv, input logic [31:0] edmd,
      input logic eifst, input logic edmst);
      vec_t v;
      v.if_req = ir;  v.if_addr = ia;
      v.dm_req = dr;  v.dm_we = dw; v.dm_addr = da; v.dm_wdata = dd;
      v.dm_lt = lt;   v.dm_st = st;
      v.e_rd = erd;   v.e_wr = ewr; v.e_addr = ea;
      v.e_ifv = eifv; v.e_ifd = eifd; v.e_dmv = edmv; v.e_dmd = edmd;
      v.e_ifst = eifst; v.e_dmst = edmst;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [7:0] ia, input logic dr,
                        input logic dw, input logic [7:0] da, input logic [31:0] dd,
                        input logic [2:0] lt, input logic [1:0] st);
      if_req_i = ir; if_addr_i = ia;
      dm_req_i = dr; dm_we_i = dw; dm_addr_i = da; dm_wdata_i = dd;
      dm_load_type_i = lt; dm_store_type_i = st;
   endtask

   logic [7:0] grant_addr [4];
   logic [7:0] exp_grant  [4];
   int         ngrant;

   initial begin
      rst = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'd0, 3'd0, 2'd0);

      //              if_req/addr   dm req/we/addr/wdata/lt/st                 rd   wr   addr   ifv  ifd            dmv  dmd            ifst dmst
      vecs[0]  = mk(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0,        3'd0, 2'd0, 1'b1, 1'b0, 8'h10, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0);
      vecs[1]  = mk(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0,        3'd0, 2'd0, 1'b0, 1'b0, 8'h10, 1'b1, 32'h00A00093, 1'b0, 32'h0,        1'b0, 1'b0);
      vecs[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0,        3'd0, 2'd0, 1'b0, 1'b0, 8'h10, 1'b0, 32'h00A00093, 1'b0, 32'h0,        1'b0, 1'b0);
      vecs[3]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 32'hDEADBEEF, 3'd0, SW,   1'b0, 1'b1, 8'h20, 1'b0, 32'h00A00093, 1'b0, 32'h0,        1'b0, 1'b1);
      vecs[4]  = mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 32'hDEADBEEF, 3'd0, SW,   1'b0, 1'b0, 8'h20, 1'b0, 32'h00A00093, 1'b1, 32'h0,        1'b0, 1'b0);
      vecs[5]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0,        3'd0, 2'd0, 1'b0, 1'b0, 8'h20, 1'b0, 32'h00A00093, 1'b0, 32'h0,        1'b0, 1'b0);
      vecs[6]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h21, 32'h0,        LBU,  2'd0, 1'b1, 1'b0, 8'h21, 1'b0, 32'h00A00093, 1'b0, 32'h0,        1'b0, 1'b1);
      vecs[7]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h21, 32'h0,        LBU,  2'd0, 1'b0, 1'b0, 8'h21, 1'b0, 32'h00A00093, 1'b1, 32'h000000BE, 1'b0, 1'b0);
      vecs[8]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0,        3'd0, 2'd0, 1'b0, 1'b0, 8'h21, 1'b0, 32'h00A00093, 1'b0, 32'h000000BE, 1'b0, 1'b0);
      vecs[9]  = mk(1'b1, 8'h20, 1'b1, 1'b0, 8'h20, 32'h0,        LW,   2'd0, 1'b1, 1'b0, 8'h20, 1'b0, 32'h00A00093, 1'b0, 32'h000000BE, 1'b1, 1'b1);
      vecs[10] = mk(1'b1, 8'h20, 1'b1, 1'b0, 8'h20, 32'h0,        LW,   2'd0, 1'b0, 1'b0, 8'h20, 1'b0, 32'h00A00093, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
      vecs[11] = mk(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 32'h0,        3'd0, 2'd0, 1'b0, 1'b0, 8'h20, 1'b0, 32'h00A00093, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
      vecs[12] = mk(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 32'h0,        3'd0, 2'd0, 1'b1, 1'b0, 8'h20, 1'b0, 32'h00A00093, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
      vecs[13] = mk(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 32'h0,        3'd0, 2'd0, 1'b0, 1'b0, 8'h20, 1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
      vecs[14] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0,        3'd0, 2'd0, 1'b0, 1'b0, 8'h20, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);

      // reset state
      #1;
      chk("reset_outputs",
          {30'd0, mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_load_type_o, mem_store_type_o,
           if_valid_o, dm_valid_o, if_stall_o, dm_stall_o},
          64'd0);
      chk("reset_rdata", {if_rdata_o, dm_rdata_o}, 64'd0);
      chk("reset_wdata", {32'd0, mem_wr_data_o}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // table: fetch, store, load, simultaneous requests
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].dm_req, vecs[i].dm_we,
               vecs[i].dm_addr, vecs[i].dm_wdata, vecs[i].dm_lt, vecs[i].dm_st);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_mem", i), {54'd0, mem_rd_en_o, mem_wr_en_o, mem_addr_o},
             {54'd0, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_addr});
         chk($sformatf("v%0d_if", i), {30'd0, if_valid_o, if_stall_o, if_rdata_o},
             {30'd0, vecs[i].e_ifv, vecs[i].e_ifst, vecs[i].e_ifd});
         chk($sformatf("v%0d_dm", i), {30'd0, dm_valid_o, dm_stall_o, dm_rdata_o},
             {30'd0, vecs[i].e_dmv, vecs[i].e_dmst, vecs[i].e_dmd});
         @(negedge clk);
      end
      chk("store_mem_word", {32'd0, mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]},
          {32'd0, 32'hDEADBEEF});

      // starvation: data held continuously, fetch waiting
`ifdef ARB_STARVE_GUARD_EN
      exp_grant[0] = 8'h20; exp_grant[1] = 8'h20; exp_grant[2] = 8'h10; exp_grant[3] = 8'h20;
`else
      exp_grant[0] = 8'h20; exp_grant[1] = 8'h20; exp_grant[2] = 8'h20; exp_grant[3] = 8'h20;
`endif
      for (int k = 0; k < 4; k++) grant_addr[k] = 8'hFF;
      ngrant = 0;
      drive(1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 32'd0, LW, 2'd0);
      for (int c = 0; c < 40 && ngrant < 4; c++) begin
         @(posedge clk);
         #1;
         if (mem_rd_en_o) begin
            grant_addr[ngrant] = mem_addr_o;
            ngrant++;
         end
      end
      if (ngrant < 4) begin
         checks++;
         failures++;
         $display("FAIL starve_timeout: got %0d grants expected 4", ngrant);
      end
      for (int k = 0; k < 4; k++)
         chk($sformatf("starve_grant%0d", k), {56'd0, grant_addr[k]}, {56'd0, exp_grant[k]});
      @(negedge clk);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'd0, 3'd0, 2'd0);
      repeat (3) @(negedge clk);

      // reset in the middle of a store
      drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 32'h12345678, 3'd0, SW);
      @(posedge clk);
      #1;
      chk("store_acc", {54'd0, mem_wr_en_o, mem_rd_en_o, mem_addr_o}, {54'd0, 1'b1, 1'b0, 8'h30});
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'd0, 3'd0, 2'd0);
      #1;
      chk("rst_wr_drop", {62'd0, mem_wr_en_o, mem_rd_en_o}, 64'd0);
      chk("rst_outputs",
          {32'd0, if_valid_o, dm_valid_o, mem_addr_o, mem_load_type_o, mem_store_type_o, 16'd0},
          64'd0);
      chk("rst_data", {if_rdata_o | dm_rdata_o, mem_wr_data_o}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mem_kept", {32'd0, mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]},
          {32'd0, 32'hA5A5A5A5});
      drive(1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 32'd0, 3'd0, 2'd0);
      @(posedge clk);
      #1;
      chk("post_rst_grant", {55'd0, mem_rd_en_o, mem_addr_o}, {55'd0, 1'b1, 8'h20});
      @(posedge clk);
      #1;
      chk("post_rst_fetch", {31'd0, if_valid_o, if_rdata_o}, {31'd0, 1'b1, 32'hDEADBEEF});
      @(negedge clk);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'd0, 3'd0, 2'd0);
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_STREAK, default 4, meaning consecutive data grants allowed while fetch waits (range 1-15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the fetch-side ports as follows:
- if_req_i, input, 1 bit: fetch request.
- if_addr_i, input, 8 bits: fetch byte address.
- if_valid_o, output, 1 bit: fetch response valid.
- if_rdata_o, output, 32 bits: fetched word.
- if_stall_o, output, 1 bit: fetch stall.
REQ-005 The block SHALL have the data-side ports as follows:
- dm_req_i, input, 1 bit: data request.
- dm_we_i, input, 1 bit: 1 = store, 0 = load.
- dm_addr_i, input, 8 bits: data byte address.
- dm_wdata_i, input, 32 bits: store data.
- dm_load_type_i, input, 3 bits: load type.
- dm_store_type_i, input, 2 bits: store type.
- dm_valid_o, output, 1 bit: response valid.
- dm_rdata_o, output, 32 bits: load data.
- dm_stall_o, output, 1 bit: data stall.
REQ-006 The block SHALL have the memory-side ports as follows:
- mem_rd_en_o, output, 1 bit.
- mem_wr_en_o, output, 1 bit.
- mem_addr_o, output, 8 bits.
- mem_wr_data_o, output, 32 bits.
- mem_load_type_o, output, 3 bits.
- mem_store_type_o, output, 2 bits.
- mem_rd_data_i, input, 32 bits: asynchronous read data from the shared byte memory.

Function
REQ-007 The block SHALL implement FSM states IDLE, IF_ACC, DM_ACC, IF_RESP, DM_RESP.
REQ-008 In IDLE, the block SHALL arbitrate as follows:
- dm_req_i=1 with grant to data -> DM_ACC.
- else if_req_i=1 -> IF_ACC.
- else stay in IDLE.
REQ-009 On entry to an ACC state, the block SHALL latch the granted request's address, write data, we and types into internal registers; mem_* outputs SHALL be driven only from these registers and the state.
REQ-010 In IF_ACC, the block SHALL drive mem_rd_en_o=1, mem_wr_en_o=0, and mem_load_type_o=`LOAD_W.
REQ-011 In IF_ACC, the block SHALL capture mem_rd_data_i into if_rdata_o at the closing edge.
REQ-012 In DM_ACC with a latched load, the block SHALL drive mem_rd_en_o=1 with the latched load type, and SHALL capture mem_rd_data_i into dm_rdata_o at the closing edge.
REQ-013 In DM_ACC with a latched store, the block SHALL drive mem_wr_en_o=1 and mem_rd_en_o=0 with the latched store type, so that the memory writes at the closing edge.
REQ-014 Outside ACC states, the block SHALL hold mem_rd_en_o and mem_wr_en_o at 0.
REQ-015 In the RESP states, the block SHALL behave as follows:
- IF_RESP: if_valid_o=1 for exactly one cycle.
- DM_RESP: dm_valid_o=1 for exactly one cycle.
- Both RESP states return to IDLE unconditionally.
REQ-016 Latency SHALL be as follows:
- Request sampled in IDLE at edge N: access in cycle N+1, valid in cycle N+2.
- Minimum occupancy SHALL be 3 cycles per access.
REQ-017 Requesters SHALL hold req and all request fields stable until their valid cycle and deassert or reissue afterwards; the block SHALL ignore field changes after latching.
REQ-018 if_rdata_o and dm_rdata_o SHALL hold their last captured values until the next capture; a store SHALL NOT modify dm_rdata_o.
REQ-019 The stall outputs SHALL be combinational:
- if_stall_o = if_req_i & ~if_valid_o.
- dm_stall_o = dm_req_i & ~dm_valid_o.
REQ-020 A request arriving in a non-IDLE state SHALL wait; no request SHALL be lost while held.

Reset
REQ-021 Asserting rst at any time SHALL immediately force the block into the following reset values:
- State = IDLE.
- All valid and enable outputs = 0.
- if_rdata_o and dm_rdata_o = 0.
- mem_addr_o, mem_wr_data_o and the type outputs = 0.
- Streak counter = 0.
REQ-022 Reset asserted during DM_ACC store SHALL drop mem_wr_en_o asynchronously, so no write occurs.
REQ-023 After rst deasserts, the first arbitration SHALL occur at the first rising edge with the block in IDLE.

Configuration
REQ-024 Macro ARB_STARVE_GUARD_EN, when defined, SHALL enable a 4-bit saturating streak counter with the following behaviour:
- Increments on each DM grant taken while if_req_i=1.
- Clears on each IF grant.
- When the counter equals MAX_STREAK and both ports request, IDLE SHALL grant IF.
REQ-025 Without ARB_STARVE_GUARD_EN, the block SHALL apply strict data priority and SHALL NOT implement the counter.

Verification
REQ-026 The bench SHALL cover a fetch only: if_req_i=1, if_addr_i=0x10, memory word 0x00A00093 -> mem_rd_en_o=1 and mem_addr_o=0x10 in cycle 1; if_valid_o=1 and if_rdata_o=0x00A00093 in cycle 2.
REQ-027 The bench SHALL cover a store then a load: SW 0xDEADBEEF to 0x20 followed by LBU 0x21 -> the write occurs in DM_ACC; the later load returns dm_rdata_o=0x000000BE.
REQ-028 The bench SHALL cover simultaneous requests: both asserted at the same edge -> DM_ACC first, IF_ACC after DM_RESP; if_stall_o=1 throughout until if_valid_o.
REQ-029 The bench SHALL cover starvation with the macro defined: MAX_STREAK=2, dm_req_i held continuously with if_req_i=1 -> grant order DM, DM, IF, DM; without the macro -> IF is never granted while dm_req_i=1.
REQ-030 The bench SHALL cover reset mid-store: rst pulsed during DM_ACC of SW 0x12345678 to 0x30 -> mem_wr_en_o=0 immediately, memory at 0x30 unchanged, all outputs 0, state IDLE.
